// File: rtl/ofdm_tx_mapper_pkg.sv
// ofdm_pkg: shared constants, types and helpers for the OFDM transmit mapper.
//   WIDTH/DEC      : sample format, Q(WIDTH-DEC).DEC two's complement
//   N_SC           : subcarriers per frame (parallel output lanes)
//   AMP            : QPSK component magnitude (1/sqrt(2) in Q8.8)
//   PILOT_*        : pilot value and bin positions (used with OFDM_PILOT_EN)
//   DATA_PER_FRAME : data symbols per frame, depends on OFDM_PILOT_EN
// Optional feature macro: OFDM_PILOT_EN (pilots on DC and Nyquist bins).
package ofdm_pkg;
    localparam int WIDTH    = 16;
    localparam int DEC      = 8;
    localparam int N_SC     = 16;
    localparam int FFT_SIZE = 32;
    localparam int IDX_W    = $clog2(N_SC);

    localparam logic signed [WIDTH-1:0] AMP      = 16'sh00B5;
    localparam logic signed [WIDTH-1:0] PILOT_RE = 16'sh0100;
    localparam logic signed [WIDTH-1:0] PILOT_IM = 16'sh0000;
    localparam int PILOT_BIN0 = 0;
    localparam int PILOT_BIN1 = N_SC / 2;

`ifdef OFDM_PILOT_EN
    localparam int DATA_PER_FRAME = N_SC - 2;
`else
    localparam int DATA_PER_FRAME = N_SC;
`endif

    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

    // Data symbol index -> subcarrier bin. With pilots, data skips bin 0
    // and bin N_SC/2, so indices before the Nyquist pilot shift by one and
    // the rest shift by two.
    function automatic logic [IDX_W-1:0] data_bin(input logic [IDX_W-1:0] idx);
`ifdef OFDM_PILOT_EN
        return (idx < IDX_W'(PILOT_BIN1 - 1)) ? idx + 1'b1 : idx + 2'd2;
`else
        return idx;
`endif
    endfunction
endpackage

// File: rtl/ofdm_tx_mapper_if.sv
// ofdm_tx_mapper_if: symbol input and frame output handshakes.
//   sym_valid/sym_ready/sym        : serial QPSK symbol stream (into mapper)
//   out_valid/out_ready            : frame handshake toward the IFFT
//   dout_real/dout_imag            : N_SC bins, bin k at [k*WIDTH +: WIDTH]
//   master : upstream source / downstream sink side
//   slave  : mapper side
interface ofdm_tx_mapper_if;
    import ofdm_pkg::*;

    logic                    sym_valid;
    logic                    sym_ready;
    logic [1:0]              sym;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_SC*WIDTH-1:0]   dout_real;
    logic [N_SC*WIDTH-1:0]   dout_imag;

    modport master (
        output sym_valid, sym, out_ready,
        input  sym_ready, out_valid, dout_real, dout_imag
    );

    modport slave (
        input  sym_valid, sym, out_ready,
        output sym_ready, out_valid, dout_real, dout_imag
    );
endinterface

// File: rtl/ofdm_tx_mapper_qpsk_map.sv
// qpsk_map: combinational QPSK constellation mapper.
//   i_sym[0] : real sign (1 = negative)
//   i_sym[1] : imag sign (1 = negative)
//   o_re/o_im: +/-AMP in Q(WIDTH-DEC).DEC
module qpsk_map
    import ofdm_pkg::*;
(
    input  logic [1:0]              i_sym,
    output logic signed [WIDTH-1:0] o_re,
    output logic signed [WIDTH-1:0] o_im
);
    assign o_re = i_sym[0] ? -AMP : AMP;
    assign o_im = i_sym[1] ? -AMP : AMP;
endmodule

// File: rtl/ofdm_tx_mapper.sv
// ofdm_tx_mapper: transmit subcarrier mapper for the 32-pt FFT OFDM link.
// Collects serial QPSK symbols into a frame of N_SC complex bins and hands
// the frame to the IFFT through a one-deep output register.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : ofdm_tx_mapper_if.slave (symbol in, frame out)
// Optional feature macro: OFDM_PILOT_EN (pilots on bins 0 and N_SC/2).
module ofdm_tx_mapper
    import ofdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ofdm_tx_mapper_if.slave   bus
);
    typedef logic [N_SC-1:0][WIDTH-1:0] frame_t;

    state_t                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_wr_idx;
    frame_t                  r_col_re, r_col_im;
    frame_t                  r_dout_re, r_dout_im;
    logic                    r_out_valid;

    logic                    w_sym_ready;
    logic                    w_acc, w_last, w_free, w_load;
    logic [IDX_W-1:0]        w_bin;
    logic signed [WIDTH-1:0] w_map_re, w_map_im;
    frame_t                  w_frame_re, w_frame_im;

    qpsk_map u_map (
        .i_sym (bus.sym),
        .o_re  (w_map_re),
        .o_im  (w_map_im)
    );

    assign w_acc  = bus.sym_valid & w_sym_ready;
    assign w_last = w_acc && (r_wr_idx == IDX_W'(DATA_PER_FRAME - 1));
    assign w_free = !r_out_valid || bus.out_ready;
    assign w_bin  = data_bin(r_wr_idx);

    // Frame as it would be after this edge's write, so the last symbol can
    // go straight to the output register on the edge that accepts it.
    always_comb begin
        w_frame_re = r_col_re;
        w_frame_im = r_col_im;
        for (int k = 0; k < N_SC; k++) begin
            if (w_acc && (w_bin == IDX_W'(k))) begin
                w_frame_re[k] = w_map_re;
                w_frame_im[k] = w_map_im;
            end
`ifdef OFDM_PILOT_EN
            if (k == PILOT_BIN0 || k == PILOT_BIN1) begin
                w_frame_re[k] = PILOT_RE;
                w_frame_im[k] = PILOT_IM;
            end
`endif
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= COLLECT;
        else     r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_last && !w_free) w_state_nxt = FULL;
            FULL:    if (w_free)            w_state_nxt = COLLECT;
            default: w_state_nxt = COLLECT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_sym_ready = (r_state == COLLECT);
        w_load      = (r_state == FULL) ? w_free : (w_last && w_free);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx <= '0;
            r_col_re <= '0;
            r_col_im <= '0;
        end else if (w_acc) begin
            r_wr_idx        <= w_last ? '0 : r_wr_idx + 1'b1;
            r_col_re[w_bin] <= w_map_re;
            r_col_im[w_bin] <= w_map_im;
        end
    end

    // Output register: a load on a handshake edge keeps out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_dout_re   <= '0;
            r_dout_im   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_dout_re   <= w_frame_re;
            r_dout_im   <= w_frame_im;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.sym_ready = w_sym_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.dout_real = r_dout_re;
    assign bus.dout_imag = r_dout_im;
endmodule

// File: tb/tb_ofdm_tx_mapper.sv
// tb_ofdm_tx_mapper: scoreboard bench for ofdm_tx_mapper.
// Build with +define+OFDM_PILOT_EN to exercise the pilot configuration.
module tb_ofdm_tx_mapper;
    import ofdm_pkg::*;

    typedef logic [N_SC*WIDTH-1:0] vec_t;
    typedef struct { vec_t re; vec_t im; } frame_t;

`ifdef OFDM_PILOT_EN
    localparam bit PIL = 1'b1;
`else
    localparam bit PIL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ofdm_tx_mapper_if bus ();
    ofdm_tx_mapper dut (.clk(clk), .rst(rst), .bus(bus));

    frame_t     sbq[$];
    frame_t     last_exp;
    logic [1:0] msyms[N_SC];
    int         mcnt = 0;
    int         n_chk = 0, n_fail = 0;
    int         n_pushed = 0, n_frames = 0;
    bit         rand_rdy = 1'b0;

    function automatic logic [WIDTH-1:0] comp(input logic b);
        return b ? 16'hFF4B : 16'h00B5;
    endfunction

    function automatic bit is_pilot(input int k);
        return PIL && (k == 0 || k == 8);
    endfunction

    function automatic frame_t build();
        frame_t f;
        int d;
        d = 0;
        f.re = '0;
        f.im = '0;
        for (int k = 0; k < N_SC; k++) begin
            if (is_pilot(k)) begin
                f.re[k*WIDTH +: WIDTH] = 16'h0100;
                f.im[k*WIDTH +: WIDTH] = 16'h0000;
            end else begin
                f.re[k*WIDTH +: WIDTH] = comp(msyms[d][0]);
                f.im[k*WIDTH +: WIDTH] = comp(msyms[d][1]);
                d++;
            end
        end
        return f;
    endfunction

    task automatic chk(input string nm, input vec_t act, input vec_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Present one symbol and return #1 after the edge that accepts it.
    task automatic send(input logic [1:0] s);
        int n;
        n = 0;
        bus.sym       = s;
        bus.sym_valid = 1'b1;
        while (!bus.sym_ready && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL send timeout: sym_ready stuck at %0b, required 1", bus.sym_ready);
            bus.sym_valid = 1'b0;
        end else begin
            msyms[mcnt] = s;
            mcnt++;
            if (mcnt == DATA_PER_FRAME) begin
                last_exp = build();
                sbq.push_back(last_exp);
                n_pushed++;
                mcnt = 0;
            end
            tick();
            bus.sym_valid = 1'b0;
        end
    endtask

    // Monitor: a frame is consumed on the edge following valid & ready.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL frame unexpected: got %h, required none", bus.dout_real);
            end else begin
                frame_t f;
                f = sbq.pop_front();
                chk("frame re", bus.dout_real, f.re);
                chk("frame im", bus.dout_imag, f.im);
                n_frames++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        frame_t f1;
        rst = 1'b1;
        bus.sym_valid = 1'b0;
        bus.sym = 2'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset out_valid", bus.out_valid, 0);
        chk1("reset sym_ready", bus.sym_ready, 1);
        chk("reset dout_real", bus.dout_real, '0);
        chk("reset dout_imag", bus.dout_imag, '0);
        rst = 1'b0;
        tick();

        // 1: all-zero symbols, latency check
        bus.out_ready = 1'b1;
        for (int i = 0; i < DATA_PER_FRAME - 1; i++) send(2'd0);
        chk1("t1 pre valid", bus.out_valid, 0);
        send(2'd0);
        chk1("t1 latency", bus.out_valid, 1);
`ifndef OFDM_PILOT_EN
        chk("t1 real", bus.dout_real, {N_SC{16'h00B5}});
        chk("t1 imag", bus.dout_imag, {N_SC{16'h00B5}});
`endif
        repeat (2) tick();

        // 2: rotating pattern
        for (int i = 0; i < DATA_PER_FRAME; i++) send(2'(i % 4));
`ifndef OFDM_PILOT_EN
        chk1("t2 lane3 re", bus.dout_real[3*WIDTH +: WIDTH], 16'hFF4B);
        chk1("t2 lane3 im", bus.dout_imag[3*WIDTH +: WIDTH], 16'hFF4B);
        chk1("t2 lane1 re", bus.dout_real[1*WIDTH +: WIDTH], 16'hFF4B);
        chk1("t2 lane1 im", bus.dout_imag[1*WIDTH +: WIDTH], 16'h00B5);
`endif
        repeat (2) tick();

        // 3: backpressure, second frame parks in FULL
        bus.out_ready = 1'b0;
        for (int i = 0; i < DATA_PER_FRAME; i++) send(2'd1);
        f1 = last_exp;
        chk1("t3 f1 valid", bus.out_valid, 1);
        for (int i = 0; i < DATA_PER_FRAME; i++) send(2'd2);
        chk1("t3 full ready", bus.sym_ready, 0);
        repeat (3) tick();
        chk1("t3 hold valid", bus.out_valid, 1);
        chk1("t3 hold ready", bus.sym_ready, 0);
        chk("t3 hold re", bus.dout_real, f1.re);
        chk("t3 hold im", bus.dout_imag, f1.im);
        bus.out_ready = 1'b1;
        tick();
        chk1("t3 b2b valid", bus.out_valid, 1);
        chk1("t3 release ready", bus.sym_ready, 1);
        chk("t3 f2 re", bus.dout_real, last_exp.re);
        chk("t3 f2 im", bus.dout_imag, last_exp.im);
        tick();
        chk1("t3 drained", bus.out_valid, 0);

        // 4: reset mid-frame discards the partial frame
        for (int i = 0; i < 7; i++) send(2'd3);
        rst = 1'b1;
        #1;
        chk1("t4 rst valid", bus.out_valid, 0);
        chk("t4 rst real", bus.dout_real, '0);
        chk("t4 rst imag", bus.dout_imag, '0);
        mcnt = 0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < DATA_PER_FRAME; i++) send(2'((i * 3 + 1) % 4));
        repeat (2) tick();

`ifdef OFDM_PILOT_EN
        // 5: pilots on DC and Nyquist
        for (int i = 0; i < DATA_PER_FRAME; i++) send(2'd3);
        chk1("t5 valid", bus.out_valid, 1);
        chk1("t5 p0 re", bus.dout_real[0 +: WIDTH], 16'h0100);
        chk1("t5 p0 im", bus.dout_imag[0 +: WIDTH], 16'h0000);
        chk1("t5 p8 re", bus.dout_real[8*WIDTH +: WIDTH], 16'h0100);
        chk1("t5 p8 im", bus.dout_imag[8*WIDTH +: WIDTH], 16'h0000);
        chk1("t5 d1 re", bus.dout_real[1*WIDTH +: WIDTH], 16'hFF4B);
        chk1("t5 d15 im", bus.dout_imag[15*WIDTH +: WIDTH], 16'hFF4B);
        repeat (2) tick();
`endif

        // 6: random gaps and random out_ready over 100 frames
        rand_rdy = 1'b1;
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < DATA_PER_FRAME; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send(2'($urandom_range(0, 3)));
            end
        end
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) tick();
        chk1("end queue empty", sbq.size(), 0);
        chk1("end frame count", n_frames, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
